// File: rtl/vector_vrf_grouped_pkg.sv
// ============================================================================
// cellrv32_package: shared types and helpers for the grouped vector VRF.
// Rev 1.0
// ============================================================================
`default_nettype none

package cellrv32_package;

  typedef logic [1:0] vrf_lmul_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } vrf_strm_state_t;

  localparam int VRF_MAX_LMUL = 8;

  // Number of registers in a group for a given log2 group size.
  function automatic logic [3:0] vrf_group_size(input vrf_lmul_t lmul);
    return 4'd1 << lmul;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vector_vrf_grouped_rd_streamer.sv
// ============================================================================
// vrf_rd_streamer: one read channel walking an LMUL register group, one beat
// per register, through a registered back-pressurable output stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module vrf_rd_streamer
  import cellrv32_package::*;
#(
  parameter int VREGS      = 32,
  parameter int ELEMENTS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(VREGS)-1:0]       req_vreg,
  input  logic [1:0]                     req_lmul,
  input  logic [$clog2(VREGS)-1:0]       req_mask_src,
  output logic                           req_err,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [ELEMENTS*DATA_WIDTH-1:0] rd_data,
  output logic [ELEMENTS-1:0]            rd_mask,
  output logic                           rd_last,
  output logic [$clog2(VREGS)-1:0]       fetch_vreg,
  output logic [$clog2(VREGS)-1:0]       fetch_mask_vreg,
  input  logic [ELEMENTS*DATA_WIDTH-1:0] fetch_data,
  input  logic [ELEMENTS-1:0]            fetch_mask
);

  localparam int c_aw = $clog2(VREGS);
  localparam int c_bw = $clog2(VRF_MAX_LMUL);
  localparam int c_ew = c_aw + 4;

  vrf_strm_state_t r_state, w_state_next;

  logic [c_aw-1:0]                r_vreg, r_mask_src;
  vrf_lmul_t                      r_lmul;
  logic [c_bw-1:0]                r_beat;
  logic                           r_valid, r_last, r_err;
  logic [ELEMENTS*DATA_WIDTH-1:0] r_data;
  logic [ELEMENTS-1:0]            r_mask;

  logic [3:0]      w_req_size, w_load_size;
  logic            w_aligned, w_in_range, w_accept, w_accept_ok, w_accept_bad;
  logic            w_handshake, w_advance, w_load, w_load_last;
  logic [c_bw-1:0] w_next_beat;

  assign w_req_size   = vrf_group_size(req_lmul);
  assign w_aligned    = (req_vreg & c_aw'(w_req_size - 4'd1)) == '0;
  assign w_in_range   = (c_ew'(req_vreg) + c_ew'(w_req_size)) <= c_ew'(VREGS);
  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_accept_ok  = w_accept && w_aligned && w_in_range;
  assign w_accept_bad = w_accept && !(w_aligned && w_in_range);

  assign w_handshake  = r_valid && rd_ready;
  assign w_advance    = (r_state == STREAM) && w_handshake && !r_last;
  assign w_load       = w_accept_ok || w_advance;

  // Beat index of whatever would be loaded into the output register now.
  assign w_next_beat  = (r_state == IDLE) ? '0 : r_beat + 1'b1;
  assign w_load_size  = (r_state == IDLE) ? w_req_size : vrf_group_size(r_lmul);
  assign w_load_last  = 4'(w_next_beat) == (w_load_size - 4'd1);

  assign fetch_vreg      = ((r_state == IDLE) ? req_vreg : r_vreg) + c_aw'(w_next_beat);
  assign fetch_mask_vreg = ((r_state == IDLE) ? req_mask_src : r_mask_src) + c_aw'(w_next_beat);

  assign req_ready = (r_state == IDLE);
  assign req_err   = r_err;
  assign rd_valid  = r_valid;
  assign rd_data   = r_data;
  assign rd_mask   = r_mask;
  assign rd_last   = r_last;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept_ok) w_state_next = STREAM;
      STREAM:  if (w_handshake && r_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vreg     <= '0;
      r_mask_src <= '0;
      r_lmul     <= '0;
      r_beat     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_mask     <= '0;
    end else begin
      r_err <= w_accept_bad;
      if (w_accept_ok) begin
        r_vreg     <= req_vreg;
        r_mask_src <= req_mask_src;
        r_lmul     <= req_lmul;
        r_beat     <= '0;
      end else if (w_advance) begin
        r_beat <= w_next_beat;
      end
      // Refill on the consuming cycle so a group streams without bubbles.
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= fetch_data;
        r_mask  <= fetch_mask;
        r_last  <= w_load_last;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_vrf_grouped.sv
// ============================================================================
// vector_vrf_grouped: VRF with NRD LMUL-group read streamers and one
// element-masked write port. Define VRF_WR_BYPASS_EN for write-first beats.
// Rev 1.0
// ============================================================================
`default_nettype none

module vector_vrf_grouped
  import cellrv32_package::*;
#(
  parameter int VREGS      = 32,
  parameter int ELEMENTS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NRD        = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  input  logic [NRD-1:0]                           req_valid,
  output logic [NRD-1:0]                           req_ready,
  input  logic [NRD-1:0][$clog2(VREGS)-1:0]        req_vreg,
  input  logic [NRD-1:0][1:0]                      req_lmul,
  input  logic [NRD-1:0][$clog2(VREGS)-1:0]        req_mask_src,
  output logic [NRD-1:0]                           req_err,
  output logic [NRD-1:0]                           rd_valid,
  input  logic [NRD-1:0]                           rd_ready,
  output logic [NRD-1:0][ELEMENTS*DATA_WIDTH-1:0]  rd_data,
  output logic [NRD-1:0][ELEMENTS-1:0]             rd_mask,
  output logic [NRD-1:0]                           rd_last,
  input  logic [ELEMENTS-1:0]                      wr_en,
  input  logic [$clog2(VREGS)-1:0]                 wr_addr,
  input  logic [ELEMENTS*DATA_WIDTH-1:0]           wr_data
);

  localparam int c_aw = $clog2(VREGS);
  localparam int c_rw = ELEMENTS * DATA_WIDTH;

  logic [c_rw-1:0] r_mem [VREGS];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int v = 0; v < VREGS; v++) r_mem[v] <= '0;
    end else begin
      for (int k = 0; k < ELEMENTS; k++) begin
        if (wr_en[k]) r_mem[wr_addr][k*DATA_WIDTH +: DATA_WIDTH] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_strm
    logic [c_aw-1:0]     w_fetch_vreg, w_fetch_mask_vreg;
    logic [c_rw-1:0]     w_fetch_data;
    logic [ELEMENTS-1:0] w_fetch_mask;

    always_comb begin
      w_fetch_data = r_mem[w_fetch_vreg];
      for (int k = 0; k < ELEMENTS; k++) w_fetch_mask[k] = r_mem[w_fetch_mask_vreg][k*DATA_WIDTH];
`ifdef VRF_WR_BYPASS_EN
      // Write-first: a beat fetched alongside a write sees the new elements.
      for (int k = 0; k < ELEMENTS; k++) begin
        if (wr_en[k] && (wr_addr == w_fetch_vreg))
          w_fetch_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        if (wr_en[k] && (wr_addr == w_fetch_mask_vreg))
          w_fetch_mask[k] = wr_data[k*DATA_WIDTH];
      end
`endif
    end

    vrf_rd_streamer #(
      .VREGS      (VREGS),
      .ELEMENTS   (ELEMENTS),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_strm (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .req_valid       (req_valid[i]),
      .req_ready       (req_ready[i]),
      .req_vreg        (req_vreg[i]),
      .req_lmul        (req_lmul[i]),
      .req_mask_src    (req_mask_src[i]),
      .req_err         (req_err[i]),
      .rd_valid        (rd_valid[i]),
      .rd_ready        (rd_ready[i]),
      .rd_data         (rd_data[i]),
      .rd_mask         (rd_mask[i]),
      .rd_last         (rd_last[i]),
      .fetch_vreg      (w_fetch_vreg),
      .fetch_mask_vreg (w_fetch_mask_vreg),
      .fetch_data      (w_fetch_data),
      .fetch_mask      (w_fetch_mask)
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_vrf_grouped.sv
// ============================================================================
// tb_vector_vrf_grouped: scoreboard bench for vector_vrf_grouped.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_vrf_grouped;

  localparam int VREGS      = 32;
  localparam int ELEMENTS   = 4;
  localparam int DATA_WIDTH = 32;
  localparam int NRD        = 2;
  localparam int c_aw       = $clog2(VREGS);
  localparam int c_rw       = ELEMENTS * DATA_WIDTH;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  logic [NRD-1:0]                 req_valid;
  logic [NRD-1:0]                 req_ready;
  logic [NRD-1:0][c_aw-1:0]       req_vreg;
  logic [NRD-1:0][1:0]            req_lmul;
  logic [NRD-1:0][c_aw-1:0]       req_mask_src;
  logic [NRD-1:0]                 req_err;
  logic [NRD-1:0]                 rd_valid;
  logic [NRD-1:0]                 rd_ready;
  logic [NRD-1:0][c_rw-1:0]       rd_data;
  logic [NRD-1:0][ELEMENTS-1:0]   rd_mask;
  logic [NRD-1:0]                 rd_last;
  logic [ELEMENTS-1:0]            wr_en;
  logic [c_aw-1:0]                wr_addr;
  logic [c_rw-1:0]                wr_data;

  always #5 clk_i = ~clk_i;

  vector_vrf_grouped #(
    .VREGS(VREGS), .ELEMENTS(ELEMENTS), .DATA_WIDTH(DATA_WIDTH), .NRD(NRD)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_vreg(req_vreg),
    .req_lmul(req_lmul), .req_mask_src(req_mask_src), .req_err(req_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_mask(rd_mask), .rd_last(rd_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct packed {
    logic [c_rw-1:0]     data;
    logic [ELEMENTS-1:0] mask;
    logic                last;
  } beat_t;

  beat_t           sbq [NRD][$];
  int              errq [NRD];
  logic [DATA_WIDTH-1:0] mdl [VREGS][ELEMENTS];
  int              n_cmp = 0;
  int              n_bad = 0;
  bit              rdy_random = 1'b0;

  task automatic chk(input string name, input logic [c_rw-1:0] act, input logic [c_rw-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [c_rw-1:0] pack4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [c_rw-1:0] mdl_reg(input int v);
    logic [c_rw-1:0] r;
    for (int k = 0; k < ELEMENTS; k++) r[k*DATA_WIDTH +: DATA_WIDTH] = mdl[v][k];
    return r;
  endfunction

  function automatic logic [ELEMENTS-1:0] mdl_mask(input int v);
    logic [ELEMENTS-1:0] m;
    for (int k = 0; k < ELEMENTS; k++) m[k] = mdl[v][k][0];
    return m;
  endfunction

  task automatic model_write(input int a, input logic [ELEMENTS-1:0] en, input logic [c_rw-1:0] d);
    for (int k = 0; k < ELEMENTS; k++) if (en[k]) mdl[a][k] = d[k*DATA_WIDTH +: DATA_WIDTH];
  endtask

  task automatic model_clear();
    for (int v = 0; v < VREGS; v++) for (int k = 0; k < ELEMENTS; k++) mdl[v][k] = '0;
  endtask

  task automatic dut_write(input int a, input logic [ELEMENTS-1:0] en, input logic [c_rw-1:0] d);
    wr_addr = c_aw'(a);
    wr_en   = en;
    wr_data = d;
    @(posedge clk_i); #1;
    wr_en = '0;
    model_write(a, en, d);
  endtask

  // Expected beats come straight from the group rules applied to the model.
  task automatic set_req(input int ch, input int vreg, input int lmul, input int msrc);
    int    sz;
    beat_t bt;
    sz = 1 << lmul;
    req_valid[ch]    = 1'b1;
    req_vreg[ch]     = c_aw'(vreg);
    req_lmul[ch]     = 2'(lmul);
    req_mask_src[ch] = c_aw'(msrc);
    if ((vreg % sz) != 0 || (vreg + sz) > VREGS) begin
      errq[ch]++;
    end else begin
      for (int b = 0; b < sz; b++) begin
        bt.data = mdl_reg(vreg + b);
        bt.mask = mdl_mask((msrc + b) % VREGS);
        bt.last = (b == sz - 1);
        sbq[ch].push_back(bt);
      end
    end
  endtask

  task automatic fire();
    for (int ch = 0; ch < NRD; ch++)
      if (req_valid[ch]) chk("req_ready_at_issue", c_rw'(req_ready[ch]), 1);
    @(posedge clk_i); #1;
    req_valid = '0;
    wr_en     = '0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && errq[0] == 0 && errq[1] == 0 &&
          rd_valid == '0 && req_ready == '1)
        done = 1'b1;
      else begin
        @(posedge clk_i); #1;
      end
    end
    chk("drain_complete", c_rw'(done), 1);
    if (!done) begin
      for (int i = 0; i < NRD; i++) begin
        sbq[i].delete();
        errq[i] = 0;
      end
    end
  endtask

  always @(posedge clk_i) begin
    if (rdy_random) begin
      #1;
      rd_ready = NRD'($urandom);
    end
  end

  always @(negedge clk_i) begin : mon
    beat_t e;
    if (!rstn_i) begin
      for (int i = 0; i < NRD; i++) begin
        sbq[i].delete();
        errq[i] = 0;
      end
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (req_err[i]) begin
          n_cmp++;
          if (errq[i] == 0) begin
            n_bad++;
            $display("FAIL req_err[%0d]: got unexpected pulse expected none", i);
          end else errq[i]--;
        end
        if (rd_valid[i]) begin
          n_cmp++;
          if (sbq[i].size() == 0) begin
            n_bad++;
            $display("FAIL beat[%0d]: got unexpected beat %h expected no beat", i, rd_data[i]);
          end else begin
            e = sbq[i][0];
            if ({rd_data[i], rd_mask[i], rd_last[i]} !== e) begin
              n_bad++;
              $display("FAIL beat[%0d]: got %h/%b/%b expected %h/%b/%b", i,
                       rd_data[i], rd_mask[i], rd_last[i], e.data, e.mask, e.last);
            end
            if (rd_ready[i]) void'(sbq[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    bit          pat [4];
    int          nw, l, v;
    logic [c_rw-1:0] newd;

    req_valid = '0; req_vreg = '0; req_lmul = '0; req_mask_src = '0;
    rd_ready = '1; wr_en = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < NRD; i++) errq[i] = 0;
    model_clear();

    #23;
    chk("reset_req_ready", c_rw'(req_ready), c_rw'(2'b11));
    chk("reset_req_err", c_rw'(req_err), 0);
    chk("reset_rd_valid", c_rw'(rd_valid), 0);
    chk("reset_rd_data", rd_data[0] | rd_data[1], 0);
    chk("reset_rd_mask_last", c_rw'({rd_mask, rd_last}), 0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Two-register group, full-rate consumer.
    dut_write(4, 4'hF, pack4(4, 3, 2, 1));
    dut_write(5, 4'hF, pack4(8, 7, 6, 5));
    set_req(0, 4, 1, 0);
    fire();
    chk("t1_valid_T1", c_rw'(rd_valid[0]), 1);
    chk("t1_data_T1", rd_data[0], pack4(4, 3, 2, 1));
    chk("t1_ready_busy", c_rw'(req_ready[0]), 0);
    chk("t1_last_T1", c_rw'(rd_last[0]), 0);
    @(posedge clk_i); #1;
    chk("t1_data_T2", rd_data[0], pack4(8, 7, 6, 5));
    chk("t1_last_T2", c_rw'(rd_last[0]), 1);
    @(posedge clk_i); #1;
    chk("t1_valid_T3", c_rw'(rd_valid[0]), 0);
    chk("t1_ready_T3", c_rw'(req_ready[0]), 1);
    drain();

    // Misaligned group.
    set_req(0, 6, 2, 0);
    fire();
    chk("t2_err_pulse", c_rw'(req_err[0]), 1);
    chk("t2_no_valid", c_rw'(rd_valid[0]), 0);
    chk("t2_ready", c_rw'(req_ready[0]), 1);
    @(posedge clk_i); #1;
    chk("t2_err_one_cycle", c_rw'(req_err[0]), 0);
    chk("t2_no_valid_after", c_rw'(rd_valid[0]), 0);
    drain();

    // Eight-register group under a 1,0,0,1 consumer.
    for (int r = 8; r < 16; r++)
      dut_write(r, 4'hF, {$urandom, $urandom, $urandom, $urandom | 32'h1});
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    set_req(0, 8, 3, 3);
    fire();
    for (int c = 0; c < 64; c++) begin
      rd_ready[0] = pat[c % 4];
      @(posedge clk_i); #1;
      if (sbq[0].size() == 0) break;
    end
    rd_ready = '1;
    drain();

    // Both streamers read register 0 with the mask taken from register 31.
    dut_write(31, 4'hF, pack4(1, 0, 3, 2));
    set_req(0, 0, 0, 31);
    set_req(1, 0, 0, 31);
    fire();
    chk("t4_mask0", c_rw'(rd_mask[0]), c_rw'(4'b0101));
    chk("t4_mask1", c_rw'(rd_mask[1]), c_rw'(4'b0101));
    chk("t4_valid_both", c_rw'(rd_valid), c_rw'(2'b11));
    drain();

    // Write landing in the same cycle the beat for that register loads.
    dut_write(2, 4'hF, pack4(32'h100, 32'h210, 32'h300, 32'h400));
    newd = pack4(32'hDEAD0000, 32'h0ABC1, 32'hBEEF0000, 32'hCAFE0000);
`ifdef VRF_WR_BYPASS_EN
    model_write(2, 4'b0010, newd);
    set_req(0, 2, 0, 2);
`else
    set_req(0, 2, 0, 2);
    model_write(2, 4'b0010, newd);
`endif
    wr_addr = c_aw'(2);
    wr_en   = 4'b0010;
    wr_data = newd;
    fire();
`ifdef VRF_WR_BYPASS_EN
    chk("t5_elem1", c_rw'(rd_data[0][DATA_WIDTH +: DATA_WIDTH]), 32'h0ABC1);
    chk("t5_mask", c_rw'(rd_mask[0]), c_rw'(4'b0010));
`else
    chk("t5_elem1", c_rw'(rd_data[0][DATA_WIDTH +: DATA_WIDTH]), 32'h210);
    chk("t5_mask", c_rw'(rd_mask[0]), c_rw'(4'b0000));
`endif
    chk("t5_elem0", c_rw'(rd_data[0][0 +: DATA_WIDTH]), 32'h100);
    drain();
    set_req(0, 2, 0, 2);
    fire();
    drain();

    // Reset in the middle of an eight-register group.
    set_req(0, 8, 3, 8);
    fire();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    #1;
    chk("t6_valid_abort", c_rw'(rd_valid), 0);
    chk("t6_ready_reset", c_rw'(req_ready), c_rw'(2'b11));
    chk("t6_data_reset", rd_data[0], 0);
    model_clear();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    chk("t6_ready_release", c_rw'(req_ready), c_rw'(2'b11));
    chk("t6_no_beats", c_rw'(rd_valid), 0);
    set_req(0, 8, 3, 8);
    fire();
    drain();

    // Randomized groups, writes and back-pressure.
    for (int it = 0; it < 40; it++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        dut_write($urandom_range(0, VREGS - 1), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      for (int ch = 0; ch < NRD; ch++) begin
        if ($urandom_range(0, 3) != 0) begin
          l = $urandom_range(0, 3);
          v = $urandom_range(0, VREGS - 1);
          if ($urandom_range(0, 4) != 0) v = v & ~((1 << l) - 1);
          set_req(ch, v, l, $urandom_range(0, VREGS - 1));
        end
      end
      rdy_random = 1'b1;
      fire();
      drain();
      rdy_random = 1'b0;
      @(posedge clk_i); #2;
      rd_ready = '1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
